// File: rtl/bitbrick_seq_mul.sv
// +-----------------------------------------------------------------------------+
// | Module   : bitbrick_seq_mul                                                  |
// | Brief    : Sequential 2/4/8-bit signed/unsigned multiplier on a 3-bit brick  |
// | Revision : 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module signed_3bit_MUL (
  input  logic signed [2:0] a_i,
  input  logic signed [2:0] b_i,
  output logic signed [5:0] p_o
);
  assign p_o = 6'(a_i) * 6'(b_i);
endmodule

module bitbrick_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           x_signed,
  input  logic           y_signed,
  input  logic [1:0]     prec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int c_max_prec = $clog2(W / 2);
  localparam int c_iw       = (c_max_prec > 0) ? c_max_prec : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d;
  logic                xs_q, xs_d, ys_q, ys_d;
  logic [c_iw-1:0]     nm1_q, nm1_d, i_q, i_d, j_q, j_d;
  logic [2*W-1:0]      acc_q, acc_d, p_q, p_d;

  logic [1:0]          w_prec_eff;
  logic [c_iw-1:0]     w_nm1;
  logic [c_iw:0]       w_xidx, w_yidx, w_ij;
  logic [1:0]          w_xc, w_yc;
  logic [2:0]          w_bx, w_by;
  logic signed [5:0]   w_brick_p;
  logic [2*W-1:0]      w_pp_ext, w_pp, w_sum;

  assign w_prec_eff = (prec > 2'(c_max_prec)) ? 2'(c_max_prec) : prec;
  assign w_nm1      = c_iw'((1 << w_prec_eff) - 1);

  // Only the top chunk of a signed operand carries its sign into the brick.
  assign w_xidx = {i_q, 1'b0};
  assign w_yidx = {j_q, 1'b0};
  assign w_xc   = x_q[w_xidx +: 2];
  assign w_yc   = y_q[w_yidx +: 2];
  assign w_bx   = {xs_q & (i_q == nm1_q) & w_xc[1], w_xc};
  assign w_by   = {ys_q & (j_q == nm1_q) & w_yc[1], w_yc};

  signed_3bit_MUL u_brick (
    .a_i (w_bx),
    .b_i (w_by),
    .p_o (w_brick_p)
  );

  generate
    if (2 * W > 6) begin : g_ext
      assign w_pp_ext = {{(2 * W - 6){w_brick_p[5]}}, w_brick_p};
    end else begin : g_trunc
      assign w_pp_ext = w_brick_p[2*W-1:0];
    end
  endgenerate

  assign w_ij  = {1'b0, i_q} + {1'b0, j_q};
  assign w_pp  = w_pp_ext << {w_ij, 1'b0};
  assign w_sum = acc_q + w_pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      nm1_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      nm1_q   <= nm1_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    nm1_d     = nm1_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    p_d       = p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          xs_d    = x_signed;
          ys_d    = y_signed;
          nm1_d   = w_nm1;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        acc_d = w_sum;
        if (j_q == nm1_q) begin
          j_d = '0;
          if (i_q == nm1_q) begin
            p_d     = w_sum;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_p = p_q;

endmodule

`default_nettype wire
